taho_monitor: RTL

TAHO_MONITOR -- requirements
Module: taho_monitor

---
 rtl/taho_monitor_if.sv | 25 ++
 rtl/taho_monitor.sv | 136 +++++++++++++
 2 files changed

// File: rtl/taho_monitor_if.sv
// Status and limit bundle between the tacho monitor and its host.
// master drives the window gate, sample and limits; slave publishes results.
interface taho_monitor_if;
    logic        sec;
    logic [15:0] freq;
    logic [15:0] lim_hi;
    logic [15:0] lim_lo;
    logic        fault_clr;
    logic [15:0] avg_freq;
    logic        valid;
    logic        over;
    logic        under;
    logic        stall;
    logic        fault;

    modport master (
        output sec, freq, lim_hi, lim_lo, fault_clr,
        input  avg_freq, valid, over, under, stall, fault
    );

    modport slave (
        input  sec, freq, lim_hi, lim_lo, fault_clr,
        output avg_freq, valid, over, under, stall, fault
    );
endinterface

// File: rtl/taho_monitor.sv
// Tacho monitor: filters the per-second frequency and raises over/under/stall/fault flags.
// Latency: valid in the 3rd cycle after sec falls; no backpressure. Macro TAHO_MONITOR_AVG_EN enables the 4-sample average.
module taho_monitor #(
    parameter int STALL_SEC = 3,
    parameter int HYST      = 16
) (
    input  logic           clock,
    input  logic           reset,
    taho_monitor_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, HIGH, LOAD, CALC, OUT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  zero_cnt;
    logic [15:0] avg_calc;
    logic [15:0] hi_clr_thr;
    logic [16:0] lo_sum;
    logic [15:0] lo_clr_thr;
    logic        over_nxt;
    logic        under_nxt;
    logic        stall_nxt;
    logic        fault_set;

    logic [15:0] avg_q;
    logic        valid_q;
    logic        over_q;
    logic        under_q;
    logic        stall_q;
    logic        fault_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.sec)  state_nxt = HIGH;
            HIGH:    if (!bus.sec) state_nxt = LOAD;
            LOAD:    state_nxt = CALC;
            CALC:    state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Consecutive zero-frequency windows, based on raw samples rather than the average
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zero_cnt <= '0;
        end else if (state == LOAD) begin
            if (bus.freq != 16'd0)    zero_cnt <= '0;
            else if (zero_cnt != 4'hF) zero_cnt <= zero_cnt + 4'd1;
        end
    end

`ifdef TAHO_MONITOR_AVG_EN
    logic [3:0][15:0] smp;
    logic [17:0]      sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            smp <= '0;
            sum <= '0;
        end else if (state == LOAD) begin
            smp <= {smp[2:0], bus.freq};
            sum <= sum + {2'b00, bus.freq} - {2'b00, smp[3]};
        end
    end

    assign avg_calc = sum[17:2];
`else
    logic [15:0] last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)              last <= '0;
        else if (state == LOAD) last <= bus.freq;
    end

    assign avg_calc = last;
`endif

    // Limits are only looked at here, while in CALC, so mid-window changes wait a window
    always_comb begin
        hi_clr_thr = (bus.lim_hi > 16'(HYST)) ? (bus.lim_hi - 16'(HYST)) : 16'd0;
        lo_sum     = {1'b0, bus.lim_lo} + 17'(HYST);
        lo_clr_thr = lo_sum[16] ? 16'hFFFF : lo_sum[15:0];

        over_nxt = over_q;
        if (avg_calc > bus.lim_hi)     over_nxt = 1'b1;
        else if (avg_calc < hi_clr_thr) over_nxt = 1'b0;

        under_nxt = under_q;
        if (bus.lim_lo == 16'd0)        under_nxt = 1'b0;
        else if (avg_calc < bus.lim_lo) under_nxt = 1'b1;
        else if (avg_calc > lo_clr_thr) under_nxt = 1'b0;

        stall_nxt = (zero_cnt >= 4'(STALL_SEC));

        // Alarm setting covers both the edge into OUT and the OUT cycle itself
        fault_set = ((state == CALC) && (over_nxt || stall_nxt)) ||
                    ((state == OUT)  && (over_q   || stall_q));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            avg_q   <= '0;
            valid_q <= 1'b0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
            stall_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= (state == CALC);
            if (state == CALC) begin
                avg_q   <= avg_calc;
                over_q  <= over_nxt;
                under_q <= under_nxt;
                stall_q <= stall_nxt;
            end
            if (fault_set)          fault_q <= 1'b1;
            else if (bus.fault_clr) fault_q <= 1'b0;
        end
    end

    assign bus.avg_freq = avg_q;
    assign bus.valid    = valid_q;
    assign bus.over     = over_q;
    assign bus.under    = under_q;
    assign bus.stall    = stall_q;
    assign bus.fault    = fault_q;

endmodule
